ibfly_stage8: RTL and testbench

- Inverse of the forward 8-point butterfly stage used in the DCT datapath; it sits at the output end of the IDCT chain.
- Takes a vector of eight sum/difference terms M0..M7 and reconstructs eight samples O0..O7:
  - O_k = (M_k + M_(7-k)) / 2
  - O_(7-k) = (M_k - M_(7-k)) / 2, for k = 0..3
- Signed fixed-point datapath, 2-stage pipeline with a valid/ready handshake and backpressure.
- Row counter that marks the last row of each block.

---
 rtl/ibfly_pkg.sv | 30 +++
 rtl/ibfly_stage8_pair.sv | 33 +++
 rtl/ibfly_stage8.sv | 150 +++++++++++++++
 tb/tb_ibfly_stage8.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ibfly_pkg.sv
// ibfly_pkg: shared constants, types and the halving helper for the inverse
// 8-point butterfly stage (ibfly_stage8).
// Optional build macro: IBFLY_ROUND_EN (round-half-up instead of floor).
package ibfly_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int N_POINTS   = 8;
  localparam int HALF       = 4;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_DATA_W:0]   wide_t;

  // Halve a sum/difference term at the default width.
  function automatic sample_t half_term(input wide_t wide);
`ifdef IBFLY_ROUND_EN
    logic signed [DEF_DATA_W+1:0] t;
    t = {wide[DEF_DATA_W], wide} + {{(DEF_DATA_W+1){1'b0}}, 1'b1};
    t = t >>> 1;
    // Only the largest difference rounds up past the positive limit.
    if (!t[DEF_DATA_W+1] && t[DEF_DATA_W-1])
      return {1'b0, {(DEF_DATA_W-1){1'b1}}};
    return t[DEF_DATA_W-1:0];
`else
    wide_t t;
    t = wide >>> 1;
    return t[DEF_DATA_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/ibfly_stage8_pair.sv
// ibfly_pair: first pipeline stage for one (M_k, M_(7-k)) pair.
// Registers the sign-extended sum and difference when en is high.
// Ports:
//   clk        rising-edge clock
//   en         shared stage-1 advance enable
//   a, b       signed DATA_W operands (M_k, M_(7-k))
//   sum, diff  registered DATA_W+1 results (a+b, a-b)
module ibfly_pair #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W:0]   sum,
  output logic signed [DATA_W:0]   diff
);

  logic signed [DATA_W:0] a_x;
  logic signed [DATA_W:0] b_x;

  assign a_x = {a[DATA_W-1], a};
  assign b_x = {b[DATA_W-1], b};

  // stage 1: one extra bit makes the sum/difference exact
  always_ff @(posedge clk) begin
    if (en) begin
      sum  <= a_x + b_x;
      diff <= a_x - b_x;
    end
  end

endmodule

// File: rtl/ibfly_stage8.sv
// ibfly_stage8: inverse 8-point butterfly, O_k = (M_k + M_(7-k))/2 and
// O_(7-k) = (M_k - M_(7-k))/2, in a 2-stage valid/ready pipeline with a row
// counter flagging the last row of each block on out_last.
// Optional build macro: IBFLY_ROUND_EN (round-half-up instead of floor).
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   in_valid, in_ready   input handshake for M0..M7
//   M0..M7               signed DATA_W sum/difference terms
//   out_valid, out_ready output handshake for O0..O7
//   O0..O7               signed DATA_W reconstructed samples
//   out_last             final row of the current block
module ibfly_stage8
  import ibfly_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ROWS_PER_BLOCK = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] M0,
  input  logic signed [DATA_W-1:0] M1,
  input  logic signed [DATA_W-1:0] M2,
  input  logic signed [DATA_W-1:0] M3,
  input  logic signed [DATA_W-1:0] M4,
  input  logic signed [DATA_W-1:0] M5,
  input  logic signed [DATA_W-1:0] M6,
  input  logic signed [DATA_W-1:0] M7,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] O0,
  output logic signed [DATA_W-1:0] O1,
  output logic signed [DATA_W-1:0] O2,
  output logic signed [DATA_W-1:0] O3,
  output logic signed [DATA_W-1:0] O4,
  output logic signed [DATA_W-1:0] O5,
  output logic signed [DATA_W-1:0] O6,
  output logic signed [DATA_W-1:0] O7,
  output logic                     out_last
);

  localparam int CNT_W = (ROWS_PER_BLOCK > 1) ? $clog2(ROWS_PER_BLOCK) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS_PER_BLOCK - 1);

  // Same halving as ibfly_pkg::half_term, but tracking this instance's DATA_W.
  function automatic logic signed [DATA_W-1:0] half_w(input logic signed [DATA_W:0] wide);
`ifdef IBFLY_ROUND_EN
    logic signed [DATA_W+1:0] t;
    t = {wide[DATA_W], wide} + {{(DATA_W+1){1'b0}}, 1'b1};
    t = t >>> 1;
    // Only the largest difference rounds up past the positive limit.
    if (!t[DATA_W+1] && t[DATA_W-1])
      return {1'b0, {(DATA_W-1){1'b1}}};
    return t[DATA_W-1:0];
`else
    logic signed [DATA_W:0] t;
    t = wide >>> 1;
    return t[DATA_W-1:0];
`endif
  endfunction

  logic signed [DATA_W-1:0] m_p0 [N_POINTS];
  logic signed [DATA_W:0]   sum_p1  [HALF];
  logic signed [DATA_W:0]   diff_p1 [HALF];
  logic signed [DATA_W-1:0] o_p2 [N_POINTS];

  logic             vld_p1;
  logic             vld_p2;
  logic             last_p1;
  logic             last_p2;
  logic [CNT_W-1:0] row_cnt;
  logic             s1_en;
  logic             s2_en;
  logic             in_xfer;

  assign m_p0[0] = M0;
  assign m_p0[1] = M1;
  assign m_p0[2] = M2;
  assign m_p0[3] = M3;
  assign m_p0[4] = M4;
  assign m_p0[5] = M5;
  assign m_p0[6] = M6;
  assign m_p0[7] = M7;

  assign s2_en    = !vld_p2 || out_ready;
  assign s1_en    = !vld_p1 || s2_en;
  assign in_ready = s1_en;
  assign in_xfer  = in_valid && s1_en;

  // stage 1: sums/differences of mirrored pairs
  for (genvar k = 0; k < HALF; k++) begin : g_pair
    ibfly_pair #(.DATA_W(DATA_W)) u_pair (
      .clk  (clk),
      .en   (s1_en),
      .a    (m_p0[k]),
      .b    (m_p0[N_POINTS-1-k]),
      .sum  (sum_p1[k]),
      .diff (diff_p1[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      row_cnt <= '0;
    end else begin
      if (s1_en) begin
        vld_p1  <= in_valid;
        last_p1 <= (row_cnt == LAST_ROW);
      end
      if (in_xfer) begin
        if (row_cnt == LAST_ROW)
          row_cnt <= '0;
        else
          row_cnt <= row_cnt + 1'b1;
      end
    end
  end

  // stage 2: halve each term; sums feed O_k, differences feed O_(7-k)
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      for (int i = 0; i < N_POINTS; i++) o_p2[i] <= '0;
    end else if (s2_en) begin
      vld_p2  <= vld_p1;
      // Gate with valid so a stale flag never reaches out_last on a bubble.
      last_p2 <= vld_p1 && last_p1;
      for (int k = 0; k < HALF; k++) begin
        o_p2[k]              <= half_w(sum_p1[k]);
        o_p2[N_POINTS-1-k]   <= half_w(diff_p1[k]);
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_last  = last_p2;
  assign O0 = o_p2[0];
  assign O1 = o_p2[1];
  assign O2 = o_p2[2];
  assign O3 = o_p2[3];
  assign O4 = o_p2[4];
  assign O5 = o_p2[5];
  assign O6 = o_p2[6];
  assign O7 = o_p2[7];

endmodule

// File: tb/tb_ibfly_stage8.sv
module tb_ibfly_stage8;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic signed [31:0] m [8];
  logic signed [31:0] o [8];

  int checks = 0;
  int errors = 0;

  ibfly_stage8 #(.DATA_W(32), .ROWS_PER_BLOCK(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M0 (m[0]), .M1 (m[1]), .M2 (m[2]), .M3 (m[3]),
    .M4 (m[4]), .M5 (m[5]), .M6 (m[6]), .M7 (m[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .O0 (o[0]), .O1 (o[1]), .O2 (o[2]), .O3 (o[3]),
    .O4 (o[4]), .O5 (o[5]), .O6 (o[6]), .O7 (o[7]),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_m();
    for (int i = 0; i < 8; i++) m[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Present one vector with out_ready high; leave the clock two edges later
  // where its result is at the output.
  task automatic send_one();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  // Stream n vectors with M0 = 2*i+2 (O0 = O7 = i+1, others 0).
  // With bp set, out_ready is held low for 4 cycles after the first output.
  task automatic run_stream(input int n, input bit bp);
    int n_in = 0;
    int n_out = 0;
    int stall = 0;
    clear_m();
    for (int cyc = 0; cyc < 60 && n_out < n; cyc++) begin
      in_valid  = (n_in < n);
      m[0]      = 32'(2 * n_in + 2);
      out_ready = !(bp && n_out == 1 && stall < 4);
      #1;
      if (!out_ready) begin
        chk("stall out_valid", 32'(out_valid), 32'd1);
        chk("stall O0 held", o[0], 32'd2);
        chk("stall in_ready low", 32'(in_ready), 32'd0);
        stall++;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream O0 #%0d", n_out), o[0], 32'(n_out + 1));
        chk($sformatf("stream O7 #%0d", n_out), o[7], 32'(n_out + 1));
        chk($sformatf("stream O3 #%0d", n_out), o[3], 32'd0);
        chk($sformatf("stream last #%0d", n_out), 32'(out_last), 32'((n_out % 8) == 7));
        n_out++;
      end
      if (in_valid && in_ready) n_in++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("stream output count", 32'(n_out), 32'(n));
    out_ready = 1'b1;
    step();
    chk("stream drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear_m();
    step();
    step();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset O0", o[0], 32'd0);
    chk("reset O7", o[7], 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;

    // Basic: 10 and 4 -> 7 and 3
    m[0] = 32'sd10;
    m[7] = 32'sd4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    clear_m();
    chk("basic not yet valid", 32'(out_valid), 32'd0);
    step();
    chk("basic out_valid", 32'(out_valid), 32'd1);
    chk("basic O0", o[0], 32'd7);
    chk("basic O7", o[7], 32'd3);
    chk("basic O1", o[1], 32'd0);
    chk("basic O6", o[6], 32'd0);
    step();
    chk("basic one cycle", 32'(out_valid), 32'd0);

    // Floor vs round: -3 and 0
    m[0] = -32'sd3;
    send_one();
`ifdef IBFLY_ROUND_EN
    chk("round O0", o[0], 32'hFFFF_FFFF);
    chk("round O7", o[7], 32'hFFFF_FFFF);
`else
    chk("floor O0", o[0], 32'hFFFF_FFFE);
    chk("floor O7", o[7], 32'hFFFF_FFFE);
`endif
    clear_m();

    // Extremes
    m[0] = 32'sh7FFF_FFFF;
    m[7] = 32'sh8000_0000;
    m[1] = 32'sh7FFF_FFFF;
    m[6] = 32'sh7FFF_FFFF;
    send_one();
`ifndef IBFLY_ROUND_EN
    chk("extreme O0", o[0], 32'hFFFF_FFFF);
`endif
    chk("extreme O7", o[7], 32'h7FFF_FFFF);
    chk("extreme O1", o[1], 32'h7FFF_FFFF);
    chk("extreme O6", o[6], 32'h0000_0000);
    clear_m();

    // Backpressure with 5 vectors
    do_reset();
    run_stream(5, 1'b1);

    // Block marker over 17 vectors
    do_reset();
    run_stream(17, 1'b0);

    // Reset mid-stream with both stages full
    do_reset();
    clear_m();
    m[0] = 32'sd100;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    step();
    step();
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full out_valid", 32'(out_valid), 32'd1);
    chk("full O0", o[0], 32'd50);
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset O0", o[0], 32'd0);
    chk("midreset O7", o[7], 32'd0);
    chk("midreset out_last", 32'(out_last), 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    chk("midreset no emission", 32'(out_valid), 32'd0);
    run_stream(8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
